pulse_stats: RTL and testbench
==============================

PULSE_STATS -- requirements
Module: pulse_stats

Interface
REQ-001 Parameter WIDTH, default 12, bit width of each incoming pulse-duration sample.
REQ-002 Parameter LOG2_N, default 3, log2 of samples per averaging window (N = 2^LOG2_N = 8).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port clear  input  1  synchronous clear of window, result and flags.
REQ-006 Port dur_in  input  WIDTH  pulse-duration sample from the upstream measurement stage.
REQ-007 Port dur_valid  input  1  one-cycle strobe; dur_in is a new sample on this cycle.
REQ-008 Port out_ready  input  1  downstream accepts the result when high with out_valid.
REQ-009 Port out_valid  output  1  result registers hold an unconsumed window result.
REQ-010 Port out_mean  output  WIDTH  truncated mean of the last completed window.
REQ-011 Port out_min  output  WIDTH  smallest sample of the last completed window.
REQ-012 Port out_max  output  WIDTH  largest sample of the last completed window.
REQ-013 Port overrun  output  1  sticky; a completed window was discarded because the result was not consumed.
REQ-014 Port fill  output  LOG2_N  number of samples accumulated in the current window.

Function
REQ-015 A sample SHALL be accepted on a clk edge where dur_valid=1, dur_in!=0, clear=0; dur_in=0 samples SHALL be dropped and not counted.
REQ-016 Accumulator SHALL be WIDTH+LOG2_N bits wide and SHALL never overflow.
REQ-017 Running min SHALL start at all-ones and running max at zero at every window start; each accepted sample updates both.
REQ-018 fill SHALL increment per accepted sample and wrap to 0 on the Nth sample.
REQ-019 On the Nth accepted sample, the window result SHALL include that sample: mean = (acc + dur_in) >> LOG2_N, min and max likewise including it.
REQ-020 The result SHALL be visible on out_mean/min/max with out_valid=1 immediately after the edge accepting the Nth sample (latency 1 edge, no extra pipeline).
REQ-021 The same edge SHALL restart the window: accumulator 0, fill 0, min all-ones, max 0.
REQ-022 Output handshake: result is consumed on an edge where out_valid=1 and out_ready=1; out_valid then falls unless REQ-024 applies.
REQ-023 out_mean/min/max SHALL hold stable while out_valid=1 and not consumed.
REQ-024 If a window completes on the same edge its predecessor is consumed, the new result SHALL load and out_valid SHALL remain 1; overrun unchanged.
REQ-025 If a window completes while out_valid=1 and out_ready=0, the new result SHALL be discarded, the held result kept, and overrun set to 1.
REQ-026 Sampling SHALL continue regardless of out_valid; the output never back-pressures input.
REQ-027 overrun SHALL clear only on reset or clear.
REQ-028 clear=1 SHALL restart the window, drive out_valid=0, overrun=0, and discard any dur_valid on that cycle; out_mean/min/max retain their values.
REQ-029 Two-state control: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on window completion; FULL->EMPTY on consume without completion or on clear.

Reset
REQ-030 While reset=1 (asynchronously), out_valid=0, out_mean=0, out_min=0, out_max=0, overrun=0, fill=0, accumulator=0, min register all-ones, max register 0.
REQ-031 Reset mid-window SHALL discard partial samples; the first accepted sample after reset release starts a fresh window.

Verification
REQ-032 8 strobes of dur_in=100, out_ready=1 -> after 8th edge out_valid=1, mean=100, min=100, max=100; fill=0.
REQ-033 samples 1..8 -> mean=4 (36>>3), min=1, max=8.
REQ-034 8 samples of 4095 -> mean=4095, min=max=4095, no accumulator wrap.
REQ-035 out_ready=0, 16 samples (values 10 then 20) -> out_mean=10 held, overrun=1; out_ready pulse -> out_valid=0, overrun still 1; clear -> overrun=0.
REQ-036 out_ready=1 on same edge as 8th sample of second window -> out_valid stays 1, outputs switch to second result, overrun=0.
REQ-037 reset asserted after 5 samples, released, then 8 samples of 7 plus interleaved dur_in=0 strobes -> mean=7, zeros ignored, fill counts only nonzero samples.

Source files
------------

// File: rtl/pulse_stats.sv
// pulse_stats: windowed mean/min/max of nonzero pulse-duration samples.
// Every 2^LOG2_N accepted samples produce one result, presented through a
// single-entry valid/ready output register. A result completing while the
// previous one is still held is dropped and flagged with a sticky overrun.
module pulse_stats #(
  parameter int WIDTH  = 12,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  dur_in,
  input  logic              dur_valid,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_mean,
  output logic [WIDTH-1:0]  out_min,
  output logic [WIDTH-1:0]  out_max,
  output logic              overrun,
  output logic [LOG2_N-1:0] fill
);

  localparam int AW = WIDTH + LOG2_N;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [LOG2_N-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]  min_q, min_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic [WIDTH-1:0]  mean_q, rmin_q, rmax_q;
  logic              ovr_q, ovr_d;

  logic              accept, last, complete, load_en, ovr_set;
  logic [AW-1:0]     sum_full;
  logic [WIDTH-1:0]  win_min, win_max;

  // Zero-duration strobes are not pulses; clear swallows any strobe.
  assign accept   = dur_valid && (dur_in != '0) && !clear;
  assign last     = (fill_q == '1);
  assign complete = accept && last;

  // Window statistics including the sample on this edge, so the Nth sample
  // lands in its own result without an extra pipeline stage.
  assign sum_full = acc_q + {{LOG2_N{1'b0}}, dur_in};
  assign win_min  = (dur_in < min_q) ? dur_in : min_q;
  assign win_max  = (dur_in > max_q) ? dur_in : max_q;

  // Window accumulator next state: restart on clear or completion.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clear || complete) begin
      acc_d  = '0;
      fill_d = '0;
      min_d  = '1;
      max_d  = '0;
    end else if (accept) begin
      acc_d  = sum_full;
      fill_d = fill_q + LOG2_N'(1);
      min_d  = win_min;
      max_d  = win_max;
    end
  end

  // Window accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      fill_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  // Output state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state: a completion keeps/makes FULL, a bare consume empties it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (complete) state_d = FULL;
        FULL:    if (out_ready && !complete) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode: load when the slot is free or being freed this edge,
  // otherwise a completing window is dropped and flagged.
  always_comb begin
    out_valid = (state_q == FULL);
    load_en   = complete && ((state_q == EMPTY) || out_ready);
    ovr_set   = complete && (state_q == FULL) && !out_ready;
    ovr_d     = clear ? 1'b0 : (ovr_q || ovr_set);
  end

  // Result registers hold until the next loaded window; clear leaves them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mean_q <= '0;
      rmin_q <= '0;
      rmax_q <= '0;
    end else if (load_en) begin
      mean_q <= sum_full[AW-1:LOG2_N];
      rmin_q <= win_min;
      rmax_q <= win_max;
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign out_mean = mean_q;
  assign out_min  = rmin_q;
  assign out_max  = rmax_q;
  assign overrun  = ovr_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_pulse_stats.sv
// Scoreboard bench for pulse_stats: a queue-based window model pushes each
// result that should be loaded; a negedge monitor checks the held result and
// pops it when the DUT hands it off.
module tb_pulse_stats;
  localparam int WIDTH  = 12;
  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;

  typedef struct {
    int mean;
    int mn;
    int mx;
  } res_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  dur_in = '0;
  logic              dur_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [WIDTH-1:0]  out_mean, out_min, out_max;
  logic              overrun;
  logic [LOG2_N-1:0] fill;

  pulse_stats #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .reset(reset), .clear(clear), .dur_in(dur_in),
    .dur_valid(dur_valid), .out_ready(out_ready), .out_valid(out_valid),
    .out_mean(out_mean), .out_min(out_min), .out_max(out_max),
    .overrun(overrun), .fill(fill)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  int   win[$];
  bit   m_valid = 0;
  bit   m_ovr = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: windows as sample lists, statistics by plain arithmetic.
  task automatic model_edge(input bit v, input int d, input bit r, input bit c);
    bit   consume, loaded;
    int   sum, mn, mx;
    res_t res;
    if (c) begin
      win.delete();
      if (m_valid && !r && exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid = 0;
      m_ovr   = 0;
      return;
    end
    consume = m_valid && r;
    loaded  = 0;
    if (v && d != 0) begin
      win.push_back(d);
      if (win.size() == N) begin
        sum = 0; mn = 1 << 30; mx = -1;
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
        end
        win.delete();
        res.mean = sum / N; res.mn = mn; res.mx = mx;
        if (!m_valid || consume) begin
          exp_q.push_back(res);
          m_valid = 1;
          loaded  = 1;
        end else begin
          m_ovr = 1;
        end
      end
    end
    if (consume && !loaded) m_valid = 0;
  endtask

  task automatic step(input bit v, input int d, input bit r, input bit c);
    dur_valid = v;
    dur_in    = WIDTH'(d);
    out_ready = r;
    clear     = c;
    @(posedge clk);
    model_edge(v, d, r, c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_mean", int'(out_mean), 0);
    chk("rst_min", int'(out_min), 0);
    chk("rst_max", int'(out_max), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_fill", int'(fill), 0);
    exp_q.delete();
    win.delete();
    m_valid = 0;
    m_ovr   = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare held result against the scoreboard head; pop on handoff.
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", int'(out_valid), int'(m_valid));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("fill", int'(fill), win.size());
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL scoreboard: out_valid with no expected result at %0t", $time);
        end else begin
          chk("mean", int'(out_mean), exp_q[0].mean);
          chk("min", int'(out_min), exp_q[0].mn);
          chk("max", int'(out_max), exp_q[0].mx);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();

    // Constant window with ready held high.
    for (int i = 0; i < N; i++) step(1, 100, 1, 0);
    step(0, 0, 1, 0);

    // Ramp 1..8.
    for (int i = 1; i <= N; i++) step(1, i, 0, 0);
    step(0, 0, 1, 0);

    // Full-scale samples: accumulator must not wrap.
    for (int i = 0; i < N; i++) step(1, 4095, 0, 0);
    step(0, 0, 1, 0);

    // Back-pressure: second window discarded, overrun sticks until clear.
    for (int i = 0; i < 2 * N; i++) step(1, (i < N) ? 10 : 20, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Consume on the same edge the next window completes.
    for (int i = 0; i < N; i++) step(1, 30, 0, 0);
    for (int i = 0; i < N - 1; i++) step(1, 50 + i, 0, 0);
    step(1, 60, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Reset mid-window, then a window of 7 with zero strobes interleaved.
    for (int i = 0; i < 5; i++) step(1, 200, 0, 0);
    do_reset();
    for (int i = 0; i < N; i++) begin
      step(1, 0, 0, 0);
      step(1, 7, 0, 0);
    end
    step(0, 0, 1, 0);

    // Clear mid-window with a strobe on the clear cycle.
    for (int i = 0; i < 3; i++) step(1, 9, 0, 0);
    step(1, 500, 0, 1);
    for (int i = 0; i < N; i++) step(1, 11, 1, 0);
    step(0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, r, c;
      int d;
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(2) != 0);
      c = ($urandom_range(80) == 0);
      case ($urandom_range(7))
        0:       d = 0;
        1:       d = 4095;
        2:       d = 1;
        default: d = int'($urandom_range(4095, 1));
      endcase
      step(v, d, r, c);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
